voice_scheduler: RTL
====================

# voice_scheduler

Per-sample sequencer for the polyphonic synth datapath. On each audio sample tick it clears the datapath tone accumulator and walks all 128 key slots, issuing load/mux strobes for every sounding key. It tracks per-key held/sounding/restart state from NIOS note events and retires voices on the datapath's NOTE_END. It then presents the summed 32-bit sample to the audio output path.

## Interface
- NUM_KEYS, 128: key slots scanned per sample; KEY width fixed at 7.
- MAX_VOICES, 32: active-voice cap; used only with VOICE_LIMIT_EN.
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high.
- SAMPLE_TICK  in  1  one-cycle pulse at the audio sample rate.
- KEY_ON_SET  in  1  note-on event for KEY_EV_IDX.
- KEY_ON_CLR  in  1  note-off event for KEY_EV_IDX.
- KEY_EV_IDX  in  7  key index for note events.
- NOTE_END  in  1  datapath: current KEY's release finished.
- TONE  in  32  datapath accumulator.
- KEY  out  7  key index driven to the datapath.
- LD_PHASE, LD_COUNT, LD_TONE  out  1 each  datapath register loads.
- TONE_MUX, COUNTER_MUX, PHASE_MUX  out  1 each  datapath mux selects.
- NOTE_ON  out  1  held bit of the current KEY.
- SAMPLE_OUT  out  32  last completed sample.
- SAMPLE_VALID  out  1  one-cycle pulse when SAMPLE_OUT updates.
- BUSY  out  1  high in any state other than IDLE.
- OVERRUN  out  1  sticky: a tick arrived while BUSY.
- VOICE_DROP  out  1  pulse: note-on refused by the voice cap.

## Operation
- Per-key state in three 128-bit vectors:
  - held: key down.
  - active: sounding.
  - restart: counter must restart.
- Note events are accepted in any cycle:
  - SET: held, active and restart all set to 1.
  - CLR: held set to 0; active and restart unchanged, so the release runs in the datapath.
  - SET and CLR in the same cycle: SET wins.
- States: IDLE, CLEAR, SETUP, LOAD, DONE.
- IDLE: on SAMPLE_TICK go to CLEAR.
- CLEAR (1 cycle): LD_TONE=1, TONE_MUX=0. Key counter k=0. Next state is SETUP.
- SETUP (KEY=k, no loads asserted) gives the wave table one cycle to read.
  - If active[k]=1, go to LOAD.
  - If active[k]=0 and k<127, increment k and stay in SETUP.
  - If active[k]=0 and k=127, go to DONE.
- LOAD (KEY=k):
  - Loads: LD_PHASE=LD_COUNT=LD_TONE=1.
  - Muxes: TONE_MUX=1, PHASE_MUX=1, COUNTER_MUX=~restart[k], NOTE_ON=held[k].
  - End of cycle: clear restart[k]; clear active[k] if NOTE_END=1.
  - A same-cycle SET on k overrides both clears.
  - If k=127, go to DONE; otherwise increment k and go to SETUP.
- DONE (1 cycle): SAMPLE_OUT <= TONE. TONE already includes the last LOAD. SAMPLE_VALID=1 in the following cycle, and the block returns to IDLE.
- All strobes are 0 outside the states listed above. KEY holds its last value in IDLE and DONE.
- A SAMPLE_TICK while BUSY is dropped and sets OVERRUN. OVERRUN clears only on RESET.
- A tick in the SAMPLE_VALID cycle is legal and is accepted, since the state is IDLE.

## Timing
- RESET values:
  - All outputs 0; KEY=0; state IDLE.
  - held, active and restart vectors cleared; voice count 0.
- RESET mid-scan aborts the scan immediately. SAMPLE_VALID is not issued and SAMPLE_OUT stays 0.
- With N active keys: tick in cycle 0, CLEAR in cycle 1, scan in cycles 2..129+N, DONE in cycle 130+N, SAMPLE_VALID in cycle 131+N.
- Worst case N=128 takes 259 cycles, well inside the 1041-cycle budget at 50 MHz / 48 kHz.
- Events take effect on the next clock edge. An event on key k applied before k's SETUP cycle affects the current scan; otherwise it affects the next scan.

## Configuration
- VOICE_LIMIT_EN defined:
  - A 0..128 counter tracks popcount(active).
  - A SET on an inactive key when count==MAX_VOICES is ignored (held is unchanged) and pulses VOICE_DROP for 1 cycle.
  - A SET on an already-active key is always accepted and does not change the count.
  - NOTE_END retirement decrements the count.
- VOICE_LIMIT_EN undefined: no cap, no counter, VOICE_DROP tied 0.

## Test plan
- No keys active, tick in cycle 0:
  - CLEAR in cycle 1; SETUP only, KEY 0..127 in cycles 2..129.
  - SAMPLE_VALID in cycle 131 with SAMPLE_OUT=TONE (0 from the stub).
- SET key 60, then tick:
  - Exactly one LOAD, with KEY=60, COUNTER_MUX=0, NOTE_ON=1; SAMPLE_VALID in cycle 132.
  - Next tick: COUNTER_MUX=1.
- CLR key 60, then NOTE_END=1 stubbed during its LOAD: active[60] clears; the following scan has no LOAD and takes 128 SETUP cycles.
- SET and CLR on key 10 in the same cycle: held[10]=1 and active[10]=1; LOAD shows NOTE_ON=1.
- Tick at cycle 50 of a scan: OVERRUN=1, the scan completes normally, and no extra SAMPLE_VALID is produced.
- With VOICE_LIMIT_EN and MAX_VOICES=2:
  - SET keys 1, 2, 3: VOICE_DROP pulses on key 3 and active[3]=0.
  - Re-SET key 1: accepted, no VOICE_DROP.
- RESET asserted mid-scan at KEY=40: all outputs 0 next cycle; state IDLE; vectors cleared.

Source files
------------

// File: rtl/voice_scheduler_if.sv
// Bus between the voice scheduler, the NIOS note-event source and the tone datapath.
// master: event source + datapath side; slave: the scheduler.
interface voice_scheduler_if;
    logic        SAMPLE_TICK;
    logic        KEY_ON_SET;
    logic        KEY_ON_CLR;
    logic [6:0]  KEY_EV_IDX;
    logic        NOTE_END;
    logic [31:0] TONE;
    logic [6:0]  KEY;
    logic        LD_PHASE;
    logic        LD_COUNT;
    logic        LD_TONE;
    logic        TONE_MUX;
    logic        COUNTER_MUX;
    logic        PHASE_MUX;
    logic        NOTE_ON;
    logic [31:0] SAMPLE_OUT;
    logic        SAMPLE_VALID;
    logic        BUSY;
    logic        OVERRUN;
    logic        VOICE_DROP;

    modport master (
        output SAMPLE_TICK, KEY_ON_SET, KEY_ON_CLR, KEY_EV_IDX, NOTE_END, TONE,
        input  KEY, LD_PHASE, LD_COUNT, LD_TONE, TONE_MUX, COUNTER_MUX, PHASE_MUX,
               NOTE_ON, SAMPLE_OUT, SAMPLE_VALID, BUSY, OVERRUN, VOICE_DROP
    );

    modport slave (
        input  SAMPLE_TICK, KEY_ON_SET, KEY_ON_CLR, KEY_EV_IDX, NOTE_END, TONE,
        output KEY, LD_PHASE, LD_COUNT, LD_TONE, TONE_MUX, COUNTER_MUX, PHASE_MUX,
               NOTE_ON, SAMPLE_OUT, SAMPLE_VALID, BUSY, OVERRUN, VOICE_DROP
    );
endinterface

// File: rtl/voice_scheduler.sv
// Per-sample key-slot sequencer for the polyphonic synth datapath.
// Optional active-voice cap enabled by defining VOICE_LIMIT_EN.
//
//   state   | meaning
//   IDLE    | waiting for SAMPLE_TICK
//   CLEAR   | zero the tone accumulator, key counter at 0
//   SETUP   | KEY presented for wave-table read, no loads
//   LOAD    | load phase/count/tone for a sounding key
//   DONE    | capture TONE into SAMPLE_OUT
module voice_scheduler #(
    parameter int NUM_KEYS = 128
`ifdef VOICE_LIMIT_EN
    , parameter int MAX_VOICES = 32
`endif
) (
    input  logic              CLK,
    input  logic              RESET,
    voice_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETUP, S_LOAD, S_DONE} state_t;

    localparam logic [6:0] LAST_KEY = 7'(NUM_KEYS - 1);

    state_t              r_state, w_state_nxt;
    logic [6:0]          r_k, w_k_nxt;
    logic [NUM_KEYS-1:0] r_held, r_active, r_restart;
    logic [31:0]         r_sample_out;
    logic                r_sample_valid, r_overrun, r_voice_drop;
    logic                w_ld_tone, w_load;
    logic                w_set_ok, w_set_drop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_ld_tone   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.SAMPLE_TICK) begin
                    w_state_nxt = S_CLEAR;
                    w_k_nxt     = '0;
                end
            end
            S_CLEAR: begin
                w_ld_tone   = 1'b1;
                w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (r_active[r_k])
                    w_state_nxt = S_LOAD;
                else if (r_k == LAST_KEY)
                    w_state_nxt = S_DONE;
                else
                    w_k_nxt = r_k + 7'd1;
            end
            S_LOAD: begin
                w_ld_tone = 1'b1;
                w_load    = 1'b1;
                if (r_k == LAST_KEY) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETUP;
                    w_k_nxt     = r_k + 7'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.KEY         = r_k;
    assign bus.LD_TONE     = w_ld_tone;
    assign bus.LD_PHASE    = w_load;
    assign bus.LD_COUNT    = w_load;
    assign bus.TONE_MUX    = w_load;
    assign bus.PHASE_MUX   = w_load;
    assign bus.COUNTER_MUX = w_load & ~r_restart[r_k];
    assign bus.NOTE_ON     = w_load & r_held[r_k];
    assign bus.BUSY        = (r_state != S_IDLE);

`ifdef VOICE_LIMIT_EN
    logic [7:0] r_voice_cnt;
    logic       w_new_voice, w_retire;

    // A SET on an already sounding key never counts against the cap.
    assign w_set_drop  = bus.KEY_ON_SET && !r_active[bus.KEY_EV_IDX] &&
                         (r_voice_cnt == 8'(MAX_VOICES));
    assign w_set_ok    = bus.KEY_ON_SET && !w_set_drop;
    assign w_new_voice = w_set_ok && !r_active[bus.KEY_EV_IDX];
    assign w_retire    = w_load && bus.NOTE_END && !(w_set_ok && (bus.KEY_EV_IDX == r_k));

    always_ff @(posedge CLK) begin
        if (RESET)
            r_voice_cnt <= '0;
        else
            r_voice_cnt <= r_voice_cnt + {7'd0, w_new_voice} - {7'd0, w_retire};
    end
`else
    assign w_set_drop = 1'b0;
    assign w_set_ok   = bus.KEY_ON_SET;
`endif

    // Scan-side clears land first so a same-cycle SET on the same key wins.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_held    <= '0;
            r_active  <= '0;
            r_restart <= '0;
        end else begin
            if (w_load) begin
                r_restart[r_k] <= 1'b0;
                if (bus.NOTE_END)
                    r_active[r_k] <= 1'b0;
            end
            if (w_set_ok) begin
                r_held[bus.KEY_EV_IDX]    <= 1'b1;
                r_active[bus.KEY_EV_IDX]  <= 1'b1;
                r_restart[bus.KEY_EV_IDX] <= 1'b1;
            end else if (bus.KEY_ON_CLR && !bus.KEY_ON_SET) begin
                r_held[bus.KEY_EV_IDX] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
            r_voice_drop   <= 1'b0;
        end else begin
            r_sample_valid <= (r_state == S_DONE);
            if (r_state == S_DONE)
                r_sample_out <= bus.TONE;
            if (bus.SAMPLE_TICK && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            r_voice_drop <= w_set_drop;
        end
    end

    assign bus.SAMPLE_OUT   = r_sample_out;
    assign bus.SAMPLE_VALID = r_sample_valid;
    assign bus.OVERRUN      = r_overrun;
    assign bus.VOICE_DROP   = r_voice_drop;

endmodule
